systolic_conv_array: RTL and testbench
======================================

# systolic_conv_array

Computes a 2×2 valid 2-D correlation of a 4×4 unsigned 8-bit image with a 3×3 unsigned 8-bit filter on a square array of P×P multiply-accumulate PEs. Parameter P selects the 1×1, 2×2 or 3×3 array organisation. All three organisations produce identical results and differ only in latency. The block is a standalone compute core: image and filter are applied as static parallel words, and the four results are registered outputs.

## Interface
- P, default 3: PE array dimension; legal values are 1, 2, 3.
- clk  in  1  rising-edge clock.
- rst  in  1  reset; one clock domain; asynchronous, active-low.
- i00..i33  in  8 each  image pixels, named i<row><col>, rows and columns 0..3.
- f00..f22  in  8 each  filter taps, named f<row><col>, rows and columns 0..2.
- o00, o01, o10, o11  out  8 each  results, named o<row><col>; registered.

## Operation
- Each output is o[r][c] = Σ_{a,b∈0..2} i[r+a][c+b]·f[a][b], for r, c ∈ {0,1}.
  - Operands are unsigned; there is no filter flip.
  - The internal accumulator is 20 bits wide, which cannot overflow (maximum sum is 585225).
  - Each output is the low 8 bits of the sum, i.e. the sum mod 256.
- While rst = 0:
  - all outputs and accumulators are 0;
  - the sequencer is in state IDLE.
- Once rst is released, the computation starts by itself. There is no start strobe.
- State machine: RUN → DONE.
  - In DONE, the outputs hold their final values until the next reset.
- Organisation for P = 1:
  - A single PE is time-multiplexed over the outputs in order o00, o01, o10, o11.
  - Within each output, taps are visited row-major: (0,0), (0,1) … (2,2).
- Organisation for P = 2 (output-stationary):
  - PE(r,c) owns o[r][c] and accumulates its 9 taps row-major.
  - Operands propagate systolically, so PE(r,c) starts r+c cycles after PE(0,0).
- Organisation for P = 3 (weight-stationary):
  - PE(a,b) holds f[a][b] and forms the product for the current window.
  - Row sums and then the column sum are pipelined.
  - One output window enters per cycle, in order o00, o01, o10, o11.
- Inputs must remain stable from reset release until DONE. Results are undefined if inputs change during RUN.

## Timing
Edge k means the k-th rising clk edge after rst goes high.
- Output write edges by organisation:
  - P = 1: o00, o01, o10, o11 are written at edges 9, 18, 27, 36. DONE is entered at edge 36.
  - P = 2: o[r][c] is written at edge 9+r+c, so o00@9, o01@10, o10@10, o11@11. DONE is entered at edge 11.
  - P = 3: o00, o01, o10, o11 are written at edges 3, 4, 5, 6. DONE is entered at edge 6.
- An output not yet written reads 0.
- Each output register changes exactly once per run.
- Reset asserted mid-RUN:
  - all outputs go to 0 immediately, asynchronously;
  - after release, the run restarts from edge 1 with full latency.
- Reset asserted in DONE: same behaviour as mid-RUN. A recomputation uses the current inputs.
- Reset held low across clock edges: outputs stay 0 and no progress is made.

## Structure
- Shared package `systolic_pkg` contains:
  - DATA_W = 8, ACC_W = 20;
  - IMG_N = 4, FLT_N = 3, OUT_N = 2;
  - the sequencer state enumeration {IDLE, RUN, DONE}.
- Sub-module `systolic_pe` is one MAC cell. It has:
  - 8-bit operand inputs with registered pass-through outputs for systolic forwarding;
  - a 20-bit accumulator with clear and enable;
  - the asynchronous active-low reset.
- The top instantiates P×P `systolic_pe` cells and selects the operand schedule and output-write logic with generate blocks on P.

## Test plan
- Reset hold: rst low for 2 cycles with any inputs → all outputs 0; they stay 0 while rst is low.
- Small vector:
  - stimulus: i rows = [9,8,2,6], [0,4,1,6], [4,10,1,1], [2,2,9,9]; f rows = [3,2,0], [2,0,1], [3,1,1];
  - required: o00=67, o01=74, o10=34, o11=59 at the edges given in Timing, for P = 1, 2 and 3.
- Wrap vector:
  - stimulus: i rows = [252,165,199,27], [93,28,86,176], [149,110,113,249], [234,207,29,30]; f rows = [181,176,207], [111,248,115], [64,95,253];
  - required: o00=89, o01=86, o10=115, o11=106 (raw sums 191577, 195926, 138355, 149098).
- Latency check, wrap vector: each output is 0 on the edge before its write edge and equals the correct value from its write edge on; DONE is reached by edge 36 / 11 / 6 for P = 1 / 2 / 3.
- Hold and re-run:
  - after DONE, wait 50 cycles → outputs are unchanged;
  - pulse rst low for 2 cycles → outputs read 0, then the same values reappear with the same latency.
- Mid-run reset, P = 1: assert rst at edge 20 (o00 already written) → all outputs drop to 0 immediately; after release, o00 is rewritten at edge 9.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared constants, sequencer states and small helpers for the systolic
// 2x2-output / 3x3-filter correlation core.
package systolic_pkg;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 20;
  localparam int IMG_N  = 4;
  localparam int FLT_N  = 3;
  localparam int OUT_N  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  // Results are the sum modulo 256, i.e. the low data-width bits.
  function automatic logic [DATA_W-1:0] acc_to_out(input logic [ACC_W-1:0] acc);
    return acc[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// One multiply-accumulate cell. Operands are forwarded through registers so
// neighbouring cells can receive them one cycle later. The sum port exposes
// the value the accumulator takes on the next edge, so a result can be
// captured on the same edge as its final product.
module systolic_pe
  import systolic_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic [ACC_W-1:0]  acc,
  output logic [ACC_W-1:0]  sum
);

  logic [2*DATA_W-1:0] prod_s;
  logic [ACC_W-1:0]    base_s;
  logic [ACC_W-1:0]    addend_s;
  logic [ACC_W-1:0]    acc_r;
  logic [DATA_W-1:0]   a_fwd_r;
  logic [DATA_W-1:0]   b_fwd_r;

  assign prod_s = {{DATA_W{1'b0}}, a_in} * {{DATA_W{1'b0}}, b_in};

  // Next accumulator value: clear drops the old sum, enable adds the product.
  always_comb begin
    base_s   = acc_r;
    addend_s = {ACC_W{1'b0}};
    if (clr) begin
      base_s = {ACC_W{1'b0}};
    end else begin
      base_s = acc_r;
    end
    if (en) begin
      addend_s = {{(ACC_W-2*DATA_W){1'b0}}, prod_s};
    end else begin
      addend_s = {ACC_W{1'b0}};
    end
    sum = base_s + addend_s;
  end

  // Accumulator and systolic forwarding registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_r   <= {ACC_W{1'b0}};
      a_fwd_r <= {DATA_W{1'b0}};
      b_fwd_r <= {DATA_W{1'b0}};
    end else begin
      acc_r   <= sum;
      a_fwd_r <= a_in;
      b_fwd_r <= b_in;
    end
  end

  assign acc   = acc_r;
  assign a_out = a_fwd_r;
  assign b_out = b_fwd_r;

endmodule

// File: rtl/systolic_conv_array.sv
// 2x2 valid correlation of a 4x4 image with a 3x3 filter on a PxP array of
// MAC cells. P=1 time-multiplexes one cell, P=2 is output-stationary with
// skewed filter forwarding, anything else builds the 3x3 weight-stationary
// array with pipelined row and column sums. The run starts on reset release
// and the results then hold until the next reset.
module systolic_conv_array
  import systolic_pkg::*;
#(
  parameter int P = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i00, i01, i02, i03,
  input  logic [7:0] i10, i11, i12, i13,
  input  logic [7:0] i20, i21, i22, i23,
  input  logic [7:0] i30, i31, i32, i33,
  input  logic [7:0] f00, f01, f02,
  input  logic [7:0] f10, f11, f12,
  input  logic [7:0] f20, f21, f22,
  output logic [7:0] o00, o01, o10, o11
);

  logic [DATA_W-1:0] img_s [IMG_N][IMG_N];
  logic [DATA_W-1:0] flt_s [FLT_N][FLT_N];
  logic [DATA_W-1:0] out_r [OUT_N*OUT_N];
  seq_state_e        state_r;
  seq_state_e        next_state_s;
  logic              finish_s;
  logic              active_s;

  assign img_s[0][0] = i00; assign img_s[0][1] = i01; assign img_s[0][2] = i02; assign img_s[0][3] = i03;
  assign img_s[1][0] = i10; assign img_s[1][1] = i11; assign img_s[1][2] = i12; assign img_s[1][3] = i13;
  assign img_s[2][0] = i20; assign img_s[2][1] = i21; assign img_s[2][2] = i22; assign img_s[2][3] = i23;
  assign img_s[3][0] = i30; assign img_s[3][1] = i31; assign img_s[3][2] = i32; assign img_s[3][3] = i33;
  assign flt_s[0][0] = f00; assign flt_s[0][1] = f01; assign flt_s[0][2] = f02;
  assign flt_s[1][0] = f10; assign flt_s[1][1] = f11; assign flt_s[1][2] = f12;
  assign flt_s[2][0] = f20; assign flt_s[2][1] = f21; assign flt_s[2][2] = f22;

  assign o00 = out_r[0];
  assign o01 = out_r[1];
  assign o10 = out_r[2];
  assign o11 = out_r[3];

  // The datapath works on every edge until the last result is written.
  assign active_s = (state_r != DONE) ? 1'b1 : 1'b0;

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Sequencer next state: leave IDLE on the first edge, finish on the last write.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: next_state_s = RUN;
      RUN: begin
        if (finish_s) begin
          next_state_s = DONE;
        end else begin
          next_state_s = RUN;
        end
      end
      DONE:    next_state_s = DONE;
      default: next_state_s = IDLE;
    endcase
  end

  if (P == 1) begin : g_p1
    logic [1:0]        tap_row_r, tap_col_r, win_r;
    logic [1:0]        row_idx_s, col_idx_s;
    logic              tap_first_s, tap_last_s;
    logic [DATA_W-1:0] px_s, wt_s, unused_a_s, unused_b_s;
    logic [ACC_W-1:0]  sum_s, unused_acc_s;

    assign row_idx_s   = {1'b0, win_r[1]} + tap_row_r;
    assign col_idx_s   = {1'b0, win_r[0]} + tap_col_r;
    assign px_s        = img_s[row_idx_s][col_idx_s];
    assign wt_s        = flt_s[tap_row_r][tap_col_r];
    assign tap_first_s = (tap_row_r == 2'd0) && (tap_col_r == 2'd0);
    assign tap_last_s  = (tap_row_r == 2'd2) && (tap_col_r == 2'd2);
    assign finish_s    = active_s && tap_last_s && (win_r == 2'd3);

    systolic_pe u_pe (
      .clk   (clk),
      .rst   (rst),
      .en    (active_s),
      .clr   (tap_first_s),
      .a_in  (px_s),
      .b_in  (wt_s),
      .a_out (unused_a_s),
      .b_out (unused_b_s),
      .acc   (unused_acc_s),
      .sum   (sum_s)
    );

    // Row-major tap walk inside each window, windows in o00..o11 order.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        tap_row_r <= 2'd0;
        tap_col_r <= 2'd0;
        win_r     <= 2'd0;
      end else if (active_s) begin
        if (tap_col_r == 2'd2) begin
          tap_col_r <= 2'd0;
          if (tap_row_r == 2'd2) begin
            tap_row_r <= 2'd0;
            win_r     <= win_r + 2'd1;
          end else begin
            tap_row_r <= tap_row_r + 2'd1;
          end
        end else begin
          tap_col_r <= tap_col_r + 2'd1;
        end
      end
    end

    // Capture the finished sum of the current window on its ninth tap.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int k = 0; k < OUT_N*OUT_N; k++) out_r[k] <= 8'd0;
      end else if (active_s && tap_last_s) begin
        out_r[win_r] <= acc_to_out(sum_s);
      end
    end

  end else if (P == 2) begin : g_p2
    logic [1:0]        tap_row_r, tap_col_r;
    logic              feed_r, feed_s;
    logic [1:0]        row_d1_r, row_d2_r, col_d1_r, col_d2_r;
    logic              v_d1_r, v_d2_r;
    logic [1:0]        pipe_row_s [3];
    logic [1:0]        pipe_col_s [3];
    logic              pipe_v_s   [3];
    logic [DATA_W-1:0] w_fwd_s [OUT_N][OUT_N];
    logic [ACC_W-1:0]  sum_all_s [OUT_N*OUT_N];
    logic [3:0]        wr_s;

    assign feed_s = feed_r && active_s;
    assign pipe_row_s[0] = tap_row_r; assign pipe_row_s[1] = row_d1_r; assign pipe_row_s[2] = row_d2_r;
    assign pipe_col_s[0] = tap_col_r; assign pipe_col_s[1] = col_d1_r; assign pipe_col_s[2] = col_d2_r;
    assign pipe_v_s[0]   = feed_s;    assign pipe_v_s[1]   = v_d1_r;   assign pipe_v_s[2]   = v_d2_r;
    assign finish_s = wr_s[3];

    for (genvar r = 0; r < OUT_N; r++) begin : g_row
      for (genvar c = 0; c < OUT_N; c++) begin : g_col
        localparam int D = r + c;
        logic [DATA_W-1:0] w_in_s, px_s, a_fwd_s;
        logic [1:0]        pr_s, pc_s;
        logic              first_s;
        logic [ACC_W-1:0]  acc_s;
        logic              unused_s;

        // Filter taps enter at PE(0,0) and ripple right and down, one edge per hop.
        if (r == 0 && c == 0) begin : g_src
          assign w_in_s = flt_s[tap_row_r][tap_col_r];
        end else if (r == 0) begin : g_left
          assign w_in_s = w_fwd_s[0][c-1];
        end else begin : g_up
          assign w_in_s = w_fwd_s[r-1][c];
        end

        assign pr_s    = pipe_row_s[D] + 2'(r);
        assign pc_s    = pipe_col_s[D] + 2'(c);
        assign px_s    = img_s[pr_s][pc_s];
        assign first_s = (pipe_row_s[D] == 2'd0) && (pipe_col_s[D] == 2'd0);
        assign wr_s[r*OUT_N+c] = pipe_v_s[D] && (pipe_row_s[D] == 2'd2) && (pipe_col_s[D] == 2'd2);
        assign unused_s = ^{a_fwd_s, acc_s, w_fwd_s[r][c]};

        systolic_pe u_pe (
          .clk   (clk),
          .rst   (rst),
          .en    (pipe_v_s[D]),
          .clr   (pipe_v_s[D] && first_s),
          .a_in  (px_s),
          .b_in  (w_in_s),
          .a_out (a_fwd_s),
          .b_out (w_fwd_s[r][c]),
          .acc   (acc_s),
          .sum   (sum_all_s[r*OUT_N+c])
        );
      end
    end

    // Nine-tap feed for PE(0,0); the other cells see it through the skew pipe.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        tap_row_r <= 2'd0;
        tap_col_r <= 2'd0;
        feed_r    <= 1'b1;
      end else if (feed_s) begin
        if (tap_col_r == 2'd2) begin
          tap_col_r <= 2'd0;
          if (tap_row_r == 2'd2) begin
            tap_row_r <= 2'd0;
            feed_r    <= 1'b0;
          end else begin
            tap_row_r <= tap_row_r + 2'd1;
          end
        end else begin
          tap_col_r <= tap_col_r + 2'd1;
        end
      end
    end

    // Skew pipe delaying tap position and valid by one and two edges.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        row_d1_r <= 2'd0; row_d2_r <= 2'd0;
        col_d1_r <= 2'd0; col_d2_r <= 2'd0;
        v_d1_r   <= 1'b0; v_d2_r   <= 1'b0;
      end else begin
        row_d1_r <= tap_row_r; row_d2_r <= row_d1_r;
        col_d1_r <= tap_col_r; col_d2_r <= col_d1_r;
        v_d1_r   <= feed_s;    v_d2_r   <= v_d1_r;
      end
    end

    // Each cell's result is captured on the edge of its last tap.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int k = 0; k < OUT_N*OUT_N; k++) out_r[k] <= 8'd0;
      end else begin
        for (int k = 0; k < OUT_N*OUT_N; k++) begin
          if (wr_s[k]) out_r[k] <= acc_to_out(sum_all_s[k]);
        end
      end
    end

  end else begin : g_p3
    logic [1:0]       win_r, pw_r, rw_r;
    logic             feed_r, feed_s, pv_r, rv_r;
    logic [1:0]       wrow_s, wcol_s;
    logic [ACC_W-1:0] prod_s [FLT_N][FLT_N];
    logic [ACC_W-1:0] rs_r [FLT_N];
    logic [ACC_W-1:0] col_sum_s;

    assign feed_s    = feed_r && active_s;
    assign wrow_s    = {1'b0, win_r[1]};
    assign wcol_s    = {1'b0, win_r[0]};
    assign col_sum_s = rs_r[0] + rs_r[1] + rs_r[2];
    assign finish_s  = rv_r && (rw_r == 2'd3);

    for (genvar a = 0; a < FLT_N; a++) begin : g_row
      for (genvar b = 0; b < FLT_N; b++) begin : g_col
        logic [DATA_W-1:0] px_s, a_fwd_s, b_fwd_s;
        logic [1:0]        pr_s, pc_s;
        logic [ACC_W-1:0]  sum_s;
        logic              unused_s;

        assign pr_s     = wrow_s + 2'(a);
        assign pc_s     = wcol_s + 2'(b);
        assign px_s     = img_s[pr_s][pc_s];
        assign unused_s = ^{a_fwd_s, b_fwd_s, sum_s};

        // Cell holds its filter tap and reloads the product every window.
        systolic_pe u_pe (
          .clk   (clk),
          .rst   (rst),
          .en    (feed_s),
          .clr   (1'b1),
          .a_in  (px_s),
          .b_in  (flt_s[a][b]),
          .a_out (a_fwd_s),
          .b_out (b_fwd_s),
          .acc   (prod_s[a][b]),
          .sum   (sum_s)
        );
      end
    end

    // One window enters per edge, o00 first.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        win_r  <= 2'd0;
        feed_r <= 1'b1;
      end else if (feed_s) begin
        win_r <= win_r + 2'd1;
        if (win_r == 2'd3) feed_r <= 1'b0;
      end
    end

    // Row-sum stage plus valid/window tags for the product and row-sum stages.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        pv_r <= 1'b0; pw_r <= 2'd0;
        rv_r <= 1'b0; rw_r <= 2'd0;
        for (int k = 0; k < FLT_N; k++) rs_r[k] <= {ACC_W{1'b0}};
      end else begin
        pv_r <= feed_s; pw_r <= win_r;
        rv_r <= pv_r;   rw_r <= pw_r;
        for (int k = 0; k < FLT_N; k++) rs_r[k] <= prod_s[k][0] + prod_s[k][1] + prod_s[k][2];
      end
    end

    // Column sum of the row sums is written to the window's output.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int k = 0; k < OUT_N*OUT_N; k++) out_r[k] <= 8'd0;
      end else if (rv_r) begin
        out_r[rw_r] <= acc_to_out(col_sum_s);
      end
    end
  end

endmodule

// File: tb/tb_systolic_conv_array.sv
// Directed bench: drives the same image/filter into P=1, P=2 and P=3 instances
// and checks every output after every edge against hand-computed results and
// write edges.
module tb_systolic_conv_array;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] img_v [16];
  logic [7:0] flt_v [9];
  logic [7:0] o_v   [3][4];
  int         we    [3][4];
  logic [7:0] exp_v [4];
  int         assert_cnt = 0;
  int         fail_cnt   = 0;

  always #5 clk = ~clk;

  systolic_conv_array #(.P(1)) u_p1 (
    .clk(clk), .rst(rst),
    .i00(img_v[0]),  .i01(img_v[1]),  .i02(img_v[2]),  .i03(img_v[3]),
    .i10(img_v[4]),  .i11(img_v[5]),  .i12(img_v[6]),  .i13(img_v[7]),
    .i20(img_v[8]),  .i21(img_v[9]),  .i22(img_v[10]), .i23(img_v[11]),
    .i30(img_v[12]), .i31(img_v[13]), .i32(img_v[14]), .i33(img_v[15]),
    .f00(flt_v[0]), .f01(flt_v[1]), .f02(flt_v[2]),
    .f10(flt_v[3]), .f11(flt_v[4]), .f12(flt_v[5]),
    .f20(flt_v[6]), .f21(flt_v[7]), .f22(flt_v[8]),
    .o00(o_v[0][0]), .o01(o_v[0][1]), .o10(o_v[0][2]), .o11(o_v[0][3])
  );

  systolic_conv_array #(.P(2)) u_p2 (
    .clk(clk), .rst(rst),
    .i00(img_v[0]),  .i01(img_v[1]),  .i02(img_v[2]),  .i03(img_v[3]),
    .i10(img_v[4]),  .i11(img_v[5]),  .i12(img_v[6]),  .i13(img_v[7]),
    .i20(img_v[8]),  .i21(img_v[9]),  .i22(img_v[10]), .i23(img_v[11]),
    .i30(img_v[12]), .i31(img_v[13]), .i32(img_v[14]), .i33(img_v[15]),
    .f00(flt_v[0]), .f01(flt_v[1]), .f02(flt_v[2]),
    .f10(flt_v[3]), .f11(flt_v[4]), .f12(flt_v[5]),
    .f20(flt_v[6]), .f21(flt_v[7]), .f22(flt_v[8]),
    .o00(o_v[1][0]), .o01(o_v[1][1]), .o10(o_v[1][2]), .o11(o_v[1][3])
  );

  systolic_conv_array #(.P(3)) u_p3 (
    .clk(clk), .rst(rst),
    .i00(img_v[0]),  .i01(img_v[1]),  .i02(img_v[2]),  .i03(img_v[3]),
    .i10(img_v[4]),  .i11(img_v[5]),  .i12(img_v[6]),  .i13(img_v[7]),
    .i20(img_v[8]),  .i21(img_v[9]),  .i22(img_v[10]), .i23(img_v[11]),
    .i30(img_v[12]), .i31(img_v[13]), .i32(img_v[14]), .i33(img_v[15]),
    .f00(flt_v[0]), .f01(flt_v[1]), .f02(flt_v[2]),
    .f10(flt_v[3]), .f11(flt_v[4]), .f12(flt_v[5]),
    .f20(flt_v[6]), .f21(flt_v[7]), .f22(flt_v[8]),
    .o00(o_v[2][0]), .o01(o_v[2][1]), .o10(o_v[2][2]), .o11(o_v[2][3])
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expd);
    assert_cnt++;
    assert (obs === expd) else begin
      fail_cnt++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expd);
    end
  endtask

  task automatic check_zero(input string tag);
    for (int d = 0; d < 3; d++)
      for (int o = 0; o < 4; o++)
        check($sformatf("%s p%0d o%0d", tag, d + 1, o), o_v[d][o], 8'd0);
  endtask

  task automatic check_final(input string tag);
    for (int d = 0; d < 3; d++)
      for (int o = 0; o < 4; o++)
        check($sformatf("%s p%0d o%0d", tag, d + 1, o), o_v[d][o], exp_v[o]);
  endtask

  // Releases reset between edges, then checks every output after each of n edges:
  // zero before its write edge, the final value from the write edge on.
  task automatic run_window(input int n, input string tag);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++)
        for (int o = 0; o < 4; o++)
          check($sformatf("%s p%0d o%0d e%0d", tag, d + 1, o, k), o_v[d][o],
                (k >= we[d][o]) ? exp_v[o] : 8'd0);
    end
  endtask

  task automatic load_small();
    img_v = '{8'd9, 8'd8, 8'd2, 8'd6, 8'd0, 8'd4, 8'd1, 8'd6,
              8'd4, 8'd10, 8'd1, 8'd1, 8'd2, 8'd2, 8'd9, 8'd9};
    flt_v = '{8'd3, 8'd2, 8'd0, 8'd2, 8'd0, 8'd1, 8'd3, 8'd1, 8'd1};
    exp_v = '{8'd67, 8'd74, 8'd34, 8'd59};
  endtask

  task automatic load_wrap();
    img_v = '{8'd252, 8'd165, 8'd199, 8'd27, 8'd93, 8'd28, 8'd86, 8'd176,
              8'd149, 8'd110, 8'd113, 8'd249, 8'd234, 8'd207, 8'd29, 8'd30};
    flt_v = '{8'd181, 8'd176, 8'd207, 8'd111, 8'd248, 8'd115, 8'd64, 8'd95, 8'd253};
    exp_v = '{8'd89, 8'd86, 8'd115, 8'd106};
  endtask

  initial begin
    we[0] = '{9, 18, 27, 36};
    we[1] = '{9, 10, 10, 11};
    we[2] = '{3, 4, 5, 6};

    // Reset hold with inputs applied.
    rst = 1'b0;
    load_small();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_zero("rst_hold");

    // Small vector: full latency profile on all organisations.
    run_window(40, "small");

    // Results hold in DONE.
    repeat (50) @(posedge clk);
    #1;
    check_final("small_hold");

    // Reset in DONE: outputs drop at once and stay low across edges.
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_zero("done_rst_async");
    load_wrap();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_zero("done_rst_held");

    // Recomputation with the wrap vector uses the new inputs and same latency.
    run_window(40, "wrap");
    repeat (50) @(posedge clk);
    #1;
    check_final("wrap_hold");

    // Plain re-run of the same inputs after a two-cycle reset pulse.
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_zero("rerun_rst");
    @(posedge clk);
    @(posedge clk);
    #1;
    check_zero("rerun_rst_held");
    run_window(40, "rerun");

    // Mid-run reset for P=1 at edge 20, after o00 was written.
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_zero("mid_pre");
    run_window(20, "mid_a");
    #1;
    rst = 1'b0;
    #1;
    check_zero("mid_rst_async");
    run_window(40, "mid_b");

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
